systolic_writeback: RTL

Result drain unit at the output end of the systolic array. Accepts one row of `ARRAY_SIZE` accumulator lanes per handshake from `mul_outcome`, requantizes each lane to signed 8-bit (rounding shift plus saturation), packs the row into `SRAM_DATA_WIDTH`-bit words, and writes them to the output SRAM. It is the write-side counterpart of the weight/data SRAM read path that feeds the array.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_wb_requant.sv | 53 +++++
 rtl/systolic_writeback.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result drain path.
// Holds default geometry, derived packing constants and the writeback FSM state type.
package systolic_pkg;

  localparam int unsigned DefArraySize     = 32;
  localparam int unsigned DefDataWidth     = 8;
  localparam int unsigned DefOutcomeWidth  = 2 * DefDataWidth + 5;
  localparam int unsigned DefSramDataWidth = 64;
  localparam int unsigned DefAddrWidth     = 10;

  // Words per result row and lanes per SRAM word.
  localparam int unsigned DefWpr = DefArraySize * DefDataWidth / DefSramDataWidth;
  localparam int unsigned DefLpw = DefSramDataWidth / DefDataWidth;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StPack,
    StDone
  } wb_state_t;

endpackage

// File: rtl/systolic_wb_requant.sv
// Single-lane requantizer: rounding arithmetic right shift followed by saturation to a
// signed DATA_WIDTH-bit value. Purely combinational.
// Optional feature macro: SYSTOLIC_WB_RELU_EN clamps negative shifted values to zero.
// Ports:
//   lane_i  - signed accumulator lane (OUTCOME_WIDTH bits)
//   shift_i - right-shift amount; rounding adds half an LSB of the result when non-zero
//   q_o     - requantized lane (DATA_WIDTH bits, two's complement)
module systolic_wb_requant #(
  parameter int unsigned OUTCOME_WIDTH = 21,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic [OUTCOME_WIDTH-1:0] lane_i,
  input  logic [4:0]               shift_i,
  output logic [DATA_WIDTH-1:0]    q_o
);

  // One guard bit so the rounding add cannot overflow.
  localparam int unsigned W = OUTCOME_WIDTH + 1;

  localparam logic signed [W-1:0] SatMax = {{(W - DATA_WIDTH + 1){1'b0}},
                                            {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [W-1:0] SatMin = ~SatMax;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] shifted;
  logic signed [W-1:0] clipped;

  always_comb begin
    ext = {lane_i[OUTCOME_WIDTH-1], lane_i};
    rnd = '0;
    if (shift_i != 5'd0) begin
      rnd = W'(1) << (shift_i - 5'd1);
    end
    sum     = ext + rnd;
    shifted = sum >>> shift_i;
    clipped = shifted;
`ifdef SYSTOLIC_WB_RELU_EN
    if (shifted[W-1]) begin
      clipped = '0;
    end
`endif
    if (clipped > SatMax) begin
      q_o = SatMax[DATA_WIDTH-1:0];
    end else if (clipped < SatMin) begin
      q_o = SatMin[DATA_WIDTH-1:0];
    end else begin
      q_o = clipped[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/systolic_writeback.sv
// Result drain unit for the systolic array. Accepts one row of accumulator lanes per
// handshake, requantizes each lane to DATA_WIDTH bits and writes the row to the output
// SRAM as WPR consecutive words starting at base_addr + row*WPR (address wraps).
// Optional feature macro: SYSTOLIC_WB_RELU_EN (negative lanes forced to zero).
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   start                    - job start, sampled only when idle
//   base_addr, num_rows,
//   shift_amt                - job configuration, latched on start
//   outcome_valid/ready      - row handshake; mul_outcome holds ARRAY_SIZE signed lanes
//   sram_we/waddr/wdata      - registered SRAM write port
//   busy                     - job in progress, through the done cycle
//   done                     - single-cycle completion pulse
module systolic_writeback
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE      = DefArraySize,
  parameter int unsigned DATA_WIDTH      = DefDataWidth,
  parameter int unsigned OUTCOME_WIDTH   = DefOutcomeWidth,
  parameter int unsigned SRAM_DATA_WIDTH = DefSramDataWidth,
  parameter int unsigned ADDR_WIDTH      = DefAddrWidth
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  input  logic [5:0]                          num_rows,
  input  logic [4:0]                          shift_amt,
  input  logic                                outcome_valid,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic                                outcome_ready,
  output logic                                sram_we,
  output logic [ADDR_WIDTH-1:0]               sram_waddr,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned Wpr    = ARRAY_SIZE * DATA_WIDTH / SRAM_DATA_WIDTH;
  localparam int unsigned Lpw    = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned Kw     = (Wpr > 1) ? $clog2(Wpr) : 1;
  localparam int unsigned VecW   = ARRAY_SIZE * OUTCOME_WIDTH;
  localparam int unsigned WordLw = Lpw * OUTCOME_WIDTH;

  wb_state_t                  state_q, state_d;
  logic [5:0]                 row_q, row_d;
  logic [5:0]                 num_rows_q, num_rows_d;
  logic [4:0]                 shift_q, shift_d;
  logic [Kw-1:0]              k_q, k_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [VecW-1:0]            vec_q, vec_d;
  logic                       we_q, we_d;
  logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
  logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                       done_q, done_d;

  logic [WordLw-1:0]          cur_lanes;
  logic [SRAM_DATA_WIDTH-1:0] word_packed;

  // Lanes belonging to the word currently being packed.
  assign cur_lanes = vec_q[k_q * WordLw +: WordLw];

  for (genvar j = 0; j < Lpw; j++) begin : g_lane
    systolic_wb_requant #(
      .OUTCOME_WIDTH(OUTCOME_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH)
    ) u_requant (
      .lane_i (cur_lanes[j*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
      .shift_i(shift_q),
      .q_o    (word_packed[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    num_rows_d = num_rows_q;
    shift_d    = shift_q;
    k_d        = k_q;
    addr_d     = addr_q;
    vec_d      = vec_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_rows_d = num_rows;
          shift_d    = shift_amt;
          row_d      = '0;
          k_d        = '0;
          // Running address equals base + row*WPR + k, wrapping naturally.
          addr_d     = base_addr;
          state_d    = (num_rows == 6'd0) ? StDone : StCapture;
        end
      end
      StCapture: begin
        if (outcome_valid) begin
          vec_d   = mul_outcome;
          k_d     = '0;
          state_d = StPack;
        end
      end
      StPack: begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = word_packed;
        addr_d  = addr_q + ADDR_WIDTH'(1);
        if (k_q == Kw'(Wpr - 1)) begin
          k_d     = '0;
          row_d   = row_q + 6'd1;
          state_d = (row_q + 6'd1 == num_rows_q) ? StDone : StCapture;
        end else begin
          k_d = k_q + Kw'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      num_rows_q <= '0;
      shift_q    <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      vec_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      num_rows_q <= num_rows_d;
      shift_q    <= shift_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      vec_q      <= vec_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  assign outcome_ready = (state_q == StCapture);
  assign sram_we       = we_q;
  assign sram_waddr    = waddr_q;
  assign sram_wdata    = wdata_q;
  // done is registered one cycle behind StDone, so busy must cover that cycle too.
  assign busy          = (state_q != StIdle) || done_q;
  assign done          = done_q;

endmodule
